// File: rtl/msm_batch_seq.sv
// Sequences MSB-first batched double-and-add commands for a shared G1 Jacobian point unit.
// Latency: all-zero scalars finish 1+DAT_BITS*(1+N) cycles after start; N=0 finishes the next cycle.
// Backpressure: a command is held stable until i_cmd_rdy; only one command is outstanding at a time.
module msm_batch_seq #(
   parameter int DAT_BITS = 256,
   parameter int NUM_IN   = 8,
   parameter int IDX_BITS = $clog2(NUM_IN)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_scl_wr,
   input  logic [IDX_BITS-1:0] i_scl_addr,
   input  logic [DAT_BITS-1:0] i_scl_dat,
   input  logic [IDX_BITS:0]   i_num,
   input  logic                i_start,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_res_inf,
   output logic                o_cmd_val,
   input  logic                i_cmd_rdy,
   output logic                o_cmd_op,
   output logic [IDX_BITS-1:0] o_cmd_idx,
   input  logic                i_res_val,
   output logic [15:0]         o_dbl_cnt,
   output logic [15:0]         o_add_cnt
);

   localparam int BIT_W = (DAT_BITS > 1) ? $clog2(DAT_BITS) : 1;
   localparam int CNT_W = IDX_BITS + 1;
   localparam logic [CNT_W-1:0] N_MAX = CNT_W'(NUM_IN);
   localparam logic [BIT_W-1:0] I_TOP = BIT_W'(DAT_BITS - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_BIT      = 3'd1;
   localparam logic [2:0] S_DBL      = 3'd2;
   localparam logic [2:0] S_DBL_WAIT = 3'd3;
   localparam logic [2:0] S_SCAN     = 3'd4;
   localparam logic [2:0] S_ADD      = 3'd5;
   localparam logic [2:0] S_ADD_WAIT = 3'd6;
   localparam logic [2:0] S_DONE     = 3'd7;

   logic [2:0]          state;
   logic [DAT_BITS-1:0] scl [NUM_IN];
   logic [CNT_W-1:0]    n_q;
   logic [CNT_W-1:0]    n_in;
   logic [BIT_W-1:0]    bit_i;
   logic [IDX_BITS-1:0] j_q;
   logic                inf_q;
   logic                res_inf_q;
   logic [15:0]         dbl_cnt;
   logic [15:0]         add_cnt;
   logic                last_j;
   logic                cur_bit;
   logic [2:0]          adv_state;
   logic [IDX_BITS-1:0] adv_j;
   logic [BIT_W-1:0]    adv_bit;

   // Outputs decode straight from state so reset drops the command valid without waiting for a clock.
   assign o_busy    = (state != S_IDLE);
   assign o_done    = (state == S_DONE);
   assign o_res_inf = (state == S_DONE) ? inf_q : res_inf_q;
   assign o_cmd_val = (state == S_DBL) || (state == S_ADD);
   assign o_cmd_op  = (state == S_ADD);
   assign o_cmd_idx = (state == S_ADD) ? j_q : '0;
   assign o_dbl_cnt = dbl_cnt;
   assign o_add_cnt = add_cnt;

   // Clamp the requested count, and work out the step to the next scalar or the next lower bit.
   always_comb begin
      n_in      = (i_num > N_MAX) ? N_MAX : i_num;
      last_j    = ({1'b0, j_q} == (n_q - CNT_W'(1)));
      cur_bit   = scl[j_q][bit_i];
      adv_state = S_SCAN;
      adv_j     = j_q + IDX_BITS'(1);
      adv_bit   = bit_i;
      if (last_j) begin
         adv_j = j_q;
         if (bit_i == '0) begin
            adv_state = S_DONE;
         end else begin
            adv_state = S_BIT;
            adv_bit   = bit_i - BIT_W'(1);
         end
      end
   end

   // Scalar slots are writable only while idle; reset wipes them.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_IN; k++) scl[k] <= '0;
      end else if ((state == S_IDLE) && i_scl_wr && ({1'b0, i_scl_addr} < N_MAX)) begin
         scl[i_scl_addr] <= i_scl_dat;
      end
   end

   // Batch sequencer: one DBL per bit once the accumulator is finite, then an ADD per set scalar bit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         n_q       <= '0;
         bit_i     <= '0;
         j_q       <= '0;
         inf_q     <= 1'b1;
         res_inf_q <= 1'b1;
         dbl_cnt   <= '0;
         add_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  n_q     <= n_in;
                  bit_i   <= I_TOP;
                  inf_q   <= 1'b1;
                  dbl_cnt <= '0;
                  add_cnt <= '0;
                  state   <= (n_in == '0) ? S_DONE : S_BIT;
               end
            end
            S_BIT: begin
               j_q   <= '0;
               state <= inf_q ? S_SCAN : S_DBL;
            end
            S_DBL: begin
               if (i_cmd_rdy) begin
                  if (dbl_cnt != 16'hFFFF) dbl_cnt <= dbl_cnt + 16'd1;
                  state <= S_DBL_WAIT;
               end
            end
            S_DBL_WAIT: begin
               if (i_res_val) state <= S_SCAN;
            end
            S_SCAN: begin
               if (cur_bit) begin
                  state <= S_ADD;
               end else begin
                  state <= adv_state;
                  j_q   <= adv_j;
                  bit_i <= adv_bit;
               end
            end
            S_ADD: begin
               if (i_cmd_rdy) begin
                  if (add_cnt != 16'hFFFF) add_cnt <= add_cnt + 16'd1;
                  inf_q <= 1'b0;
                  state <= S_ADD_WAIT;
               end
            end
            S_ADD_WAIT: begin
               if (i_res_val) begin
                  state <= adv_state;
                  j_q   <= adv_j;
                  bit_i <= adv_bit;
               end
            end
            S_DONE: begin
               res_inf_q <= inf_q;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msm_batch_seq.sv
// Bench for msm_batch_seq: emulates the point unit and predicts the command stream per batch.
// Latency: done-pulse latency is measured from the start-sampling edge.
// Backpressure: the emulated unit can hold i_cmd_rdy low and inject stray result pulses.
module tb_msm_batch_seq;

   localparam int DB = 256;
   localparam int NI = 8;
   localparam int IB = 3;

   logic          clk;
   logic          i_rst;
   logic          i_scl_wr;
   logic [IB-1:0] i_scl_addr;
   logic [DB-1:0] i_scl_dat;
   logic [IB:0]   i_num;
   logic          i_start;
   logic          o_busy, o_done, o_res_inf, o_cmd_val, o_cmd_op;
   logic          i_cmd_rdy, i_res_val;
   logic [IB-1:0] o_cmd_idx;
   logic [15:0]   o_dbl_cnt, o_add_cnt;

   msm_batch_seq #(.DAT_BITS(DB), .NUM_IN(NI)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_scl_wr(i_scl_wr), .i_scl_addr(i_scl_addr),
      .i_scl_dat(i_scl_dat), .i_num(i_num), .i_start(i_start), .o_busy(o_busy),
      .o_done(o_done), .o_res_inf(o_res_inf), .o_cmd_val(o_cmd_val), .i_cmd_rdy(i_cmd_rdy),
      .o_cmd_op(o_cmd_op), .o_cmd_idx(o_cmd_idx), .i_res_val(i_res_val),
      .o_dbl_cnt(o_dbl_cnt), .o_add_cnt(o_add_cnt)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // model state
   logic [DB-1:0] m_scl [NI];
   int  exp_q[$];
   int  exp_dbl, exp_add;
   logic exp_inf;

   // unit emulation / monitor shared state
   int  stall = 0;
   int  res_dly = 3;
   logic spur = 0;
   logic acc = 0;
   int  acc_n = 0;
   logic done_seen = 0;
   int  done_cyc = 0;
   int  st_cyc = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected stream from the scalar rules: DBL before each bit once something was added, then ADD per set bit.
   task automatic build(input int n_raw);
      int n;
      logic inf;
      n = (n_raw > NI) ? NI : n_raw;
      exp_q.delete();
      exp_dbl = 0;
      exp_add = 0;
      inf = 1'b1;
      if (n > 0) begin
         for (int i = DB - 1; i >= 0; i--) begin
            if (!inf) begin
               exp_q.push_back(0);
               exp_dbl++;
            end
            for (int j = 0; j < n; j++) begin
               if (m_scl[j][i]) begin
                  exp_q.push_back(16 + j);
                  exp_add++;
                  inf = 1'b0;
               end
            end
         end
      end
      exp_inf = inf;
   endtask

   // Point unit: optional ready stall, result pulse res_dly cycles after acceptance, optional stray pulses.
   int res_cd = 0;
   int vcnt = 0;
   initial begin
      i_cmd_rdy = 1'b1;
      i_res_val = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         i_res_val = 1'b0;
         if (acc) begin
            res_cd = res_dly;
         end else if (res_cd > 0) begin
            res_cd--;
            if (res_cd == 0) i_res_val = 1'b1;
         end else if (spur && o_busy) begin
            i_res_val = 1'b1;
         end
         if (o_cmd_val) vcnt++;
         else vcnt = 0;
         i_cmd_rdy = (stall == 0) || (vcnt > stall);
      end
   end

   // Compare process: command stream, handshake stability, done results.
   logic pv = 0, pacc = 0, pop = 0, pd = 0;
   logic [IB-1:0] pidx = '0;
   always @(negedge clk) begin
      int e;
      if (i_rst) begin
         acc = 1'b0;
         pv = 0; pacc = 0; pd = 0;
      end else begin
         if (pv && !pacc) begin
            chk("hold_val", 32'(o_cmd_val), 32'd1);
            chk("hold_op",  32'(o_cmd_op),  32'(pop));
            chk("hold_idx", 32'(o_cmd_idx), 32'(pidx));
         end
         acc = o_cmd_val && i_cmd_rdy;
         if (o_cmd_val) begin
            chk("val_busy", 32'(o_busy), 32'd1);
            if (!o_cmd_op) chk("dbl_idx0", 32'(o_cmd_idx), 32'd0);
         end
         if (acc) begin
            acc_n++;
            chk("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("cmd_op",  32'(o_cmd_op),  32'(e / 16));
               chk("cmd_idx", 32'(o_cmd_idx), 32'(e % 16));
            end
         end
         if (pd) chk("done_pulse", 32'(o_done), 32'd0);
         if (o_done) begin
            chk("done_busy", 32'(o_busy), 32'd1);
            chk("done_dbl",  32'(o_dbl_cnt), 32'(exp_dbl));
            chk("done_add",  32'(o_add_cnt), 32'(exp_add));
            chk("done_inf",  32'(o_res_inf), 32'(exp_inf));
            chk("done_left", 32'(exp_q.size()), 32'd0);
            done_seen = 1'b1;
            done_cyc = cyc;
         end
         pv = o_cmd_val; pacc = acc; pop = o_cmd_op; pidx = o_cmd_idx; pd = o_done;
      end
   end

   task automatic wr(input int a, input logic [DB-1:0] d);
      @(posedge clk); #1;
      i_scl_wr = 1'b1;
      i_scl_addr = IB'(a);
      i_scl_dat = d;
      m_scl[a] = d;
      @(posedge clk); #1;
      i_scl_wr = 1'b0;
   endtask

   task automatic go(input int n, input logic w, input int wa, input logic [DB-1:0] wd);
      if (w) m_scl[wa] = wd;
      build(n);
      done_seen = 1'b0;
      @(posedge clk); #1;
      i_num = (IB + 1)'(n);
      i_start = 1'b1;
      i_scl_wr = w;
      i_scl_addr = IB'(wa);
      i_scl_dat = wd;
      st_cyc = cyc;
      @(posedge clk); #1;
      i_start = 1'b0;
      i_scl_wr = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      for (int k = 0; k < 6000 && !done_seen; k++) @(posedge clk);
      chk("done_seen", 32'(done_seen), 32'd1);
      lat = done_cyc - st_cyc;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic rst_vals(input string tag);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
      chk({tag, "_val"},  32'(o_cmd_val), 32'd0);
      chk({tag, "_op"},   32'(o_cmd_op), 32'd0);
      chk({tag, "_idx"},  32'(o_cmd_idx), 32'd0);
      chk({tag, "_inf"},  32'(o_res_inf), 32'd1);
      chk({tag, "_dbl"},  32'(o_dbl_cnt), 32'd0);
      chk({tag, "_add"},  32'(o_add_cnt), 32'd0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int a0;
      i_rst = 1'b1;
      i_scl_wr = 1'b0;
      i_scl_addr = '0;
      i_scl_dat = '0;
      i_num = '0;
      i_start = 1'b0;
      for (int k = 0; k < NI; k++) m_scl[k] = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_vals("reset");
      i_rst = 1'b0;

      // s0=1: single ADD0, no DBL
      wr(0, 256'd1);
      go(1, 1'b0, 0, '0);
      wait_done(lat);
      chk("s1_dbl_lit", 32'(o_dbl_cnt), 32'd0);
      chk("s1_add_lit", 32'(o_add_cnt), 32'd1);
      chk("s1_inf_lit", 32'(o_res_inf), 32'd0);

      // s0=5: ADD0, DBL, DBL, ADD0
      wr(0, 256'd5);
      go(1, 1'b0, 0, '0);
      wait_done(lat);
      chk("s5_dbl_lit", 32'(o_dbl_cnt), 32'd2);
      chk("s5_add_lit", 32'(o_add_cnt), 32'd2);

      // s0=3, s1=2: ADD0, ADD1, DBL, ADD0
      wr(0, 256'd3);
      wr(1, 256'd2);
      go(2, 1'b0, 0, '0);
      wait_done(lat);
      chk("s32_dbl_lit", 32'(o_dbl_cnt), 32'd1);
      chk("s32_add_lit", 32'(o_add_cnt), 32'd3);
      chk("s32_inf_lit", 32'(o_res_inf), 32'd0);

      // all-zero N=4, then N=0
      wr(0, '0);
      wr(1, '0);
      go(4, 1'b0, 0, '0);
      wait_done(lat);
      chk("lat_n4", 32'(lat), 32'd1281);
      chk("z_inf_lit", 32'(o_res_inf), 32'd1);
      go(0, 1'b0, 0, '0);
      wait_done(lat);
      chk("lat_n0", 32'(lat), 32'd1);

      // write+start same cycle, ready stalls, stray results, dropped write/start while busy
      stall = 10;
      spur = 1'b1;
      go(1, 1'b1, 0, 256'd5);
      repeat (5) @(posedge clk);
      #1;
      chk("busy_mid", 32'(o_busy), 32'd1);
      i_scl_wr = 1'b1; i_scl_addr = '0; i_scl_dat = 256'd7;
      i_start = 1'b1; i_num = 4'd2;
      @(posedge clk); #1;
      i_scl_wr = 1'b0; i_start = 1'b0;
      wait_done(lat);
      chk("stall_dbl_lit", 32'(o_dbl_cnt), 32'd2);
      chk("stall_add_lit", 32'(o_add_cnt), 32'd2);
      stall = 0;
      spur = 1'b0;
      go(1, 1'b0, 0, '0);
      wait_done(lat);
      chk("keep_add_lit", 32'(o_add_cnt), 32'd2);

      // reset during ADD_WAIT
      go(1, 1'b0, 0, '0);
      a0 = acc_n;
      for (int k = 0; k < 2000 && acc_n == a0; k++) @(posedge clk);
      #3;
      chk("pre_rst_add", 32'(o_add_cnt), 32'd1);
      chk("pre_rst_busy", 32'(o_busy), 32'd1);
      i_rst = 1'b1;
      #1;
      rst_vals("midrst");
      exp_q.delete();
      for (int k = 0; k < NI; k++) m_scl[k] = '0;
      repeat (5) @(posedge clk);
      #1;
      i_rst = 1'b0;
      go(1, 1'b0, 0, '0);
      wait_done(lat);
      chk("lat_cleared", 32'(lat), 32'(1 + DB * 2));
      wr(0, 256'd5);
      go(1, 1'b0, 0, '0);
      wait_done(lat);
      chk("post_rst_add_lit", 32'(o_add_cnt), 32'd2);

      // i_num=9 clamps to 8: s0=5, s7=1 gives ADD0, DBL, DBL, ADD0, ADD7
      wr(7, 256'd1);
      go(9, 1'b0, 0, '0);
      wait_done(lat);
      chk("clamp_dbl_lit", 32'(o_dbl_cnt), 32'd2);
      chk("clamp_add_lit", 32'(o_add_cnt), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/msm_batch_seq.md
Name: msm_batch_seq

Overview:
- Sequencer for batched-doubling G1 multi-exponentiation, MSB-first.
- Stores up to NUM_IN scalars locally.
- Drives a shared external Jacobian point add/double unit with one command at a time. The unit owns the accumulator and the point RAM.
- Issues DBL once per bit position, then ADD(j) for every scalar j whose current bit is 1. Skips DBL while the accumulator is still the point at infinity.

Parameters:
- DAT_BITS, 256, scalar width in bits.
- NUM_IN, 8, maximum scalars/points per batch.
- IDX_BITS, $clog2(NUM_IN), width of point index and count fields.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_scl_wr  in  1  scalar write strobe; accepted only when o_busy=0
- i_scl_addr  in  IDX_BITS  scalar slot
- i_scl_dat  in  DAT_BITS  scalar value
- i_num  in  IDX_BITS+1  active scalar count; sampled at start; values >NUM_IN clamp to NUM_IN
- i_start  in  1  start pulse; ignored while o_busy=1
- o_busy  out  1  high from the cycle after start through the o_done cycle
- o_done  out  1  one-cycle completion pulse
- o_res_inf  out  1  high if no ADD was issued in the last batch
- o_cmd_val  out  1  command valid
- i_cmd_rdy  in  1  point unit accepts command
- o_cmd_op  out  1  0=DBL, 1=ADD
- o_cmd_idx  out  IDX_BITS  point index for ADD; 0 for DBL
- i_res_val  in  1  pulse: point unit finished the accepted command
- o_dbl_cnt  out  16  DBL commands accepted this batch
- o_add_cnt  out  16  ADD commands accepted this batch

Behaviour:
- Reset values:
  - state=IDLE.
  - o_busy, o_done, o_cmd_val, o_cmd_op, o_cmd_idx = 0.
  - o_res_inf=1.
  - o_dbl_cnt, o_add_cnt = 0.
  - Scalar storage = 0.
- Reset mid-operation aborts immediately: o_cmd_val drops asynchronously and any pending i_res_val is ignored. Scalar storage is also cleared.
- States: IDLE, BIT, DBL, DBL_WAIT, SCAN, ADD, ADD_WAIT, DONE.
- IDLE:
  - Scalar writes take effect on the clock edge.
  - On i_start with clamped N>0: latch N, set bit index i=DAT_BITS-1, set inf=1, clear both counters, go to BIT.
  - On i_start with N=0: go to DONE (no commands).
- BIT (1 cycle): set j=0; go to SCAN if inf=1, else go to DBL.
- DBL: o_cmd_val=1, op=0, idx=0. On val&rdy: increment o_dbl_cnt, go to DBL_WAIT (o_cmd_val=0 on the next cycle).
- DBL_WAIT: wait for i_res_val, then go to SCAN.
- SCAN (1 cycle per index): examine scalar[j][i].
  - If 1: go to ADD with idx=j.
  - If 0 and j<N-1: increment j, stay in SCAN.
  - If 0 and j=N-1: if i=0 go to DONE; else decrement i and go to BIT.
- ADD: o_cmd_val=1, op=1, idx=j. On val&rdy: increment o_add_cnt, set inf=0, go to ADD_WAIT.
- ADD_WAIT: on i_res_val, apply the same next-index/next-bit rule as a 0 bit in SCAN (j=N-1 check first).
- DONE (1 cycle): o_done=1, o_res_inf=inf, o_busy=1; then go to IDLE.
  - o_res_inf updates only in DONE.
  - Counters hold until the next start.
- Handshake rules:
  - Once o_cmd_val rises, op and idx stay stable and o_cmd_val stays high until i_cmd_rdy. No combinational path from i_cmd_rdy to o_cmd_val.
  - At most one outstanding command.
  - i_res_val outside DBL_WAIT/ADD_WAIT is ignored.
  - i_res_val in the same cycle as acceptance is ignored (result is expected on a later cycle).
- Scalar writes while busy are dropped. Start while busy is dropped. Start and a write in the same IDLE cycle: the write commits and start uses the new value.
- Latency with zero-cycle unit response excluded:
  - All-zero scalars give o_done exactly 1+DAT_BITS*(1+N) cycles after the start edge.
  - N=0 gives o_done 1 cycle after start.
- Counters saturate at 16'hFFFF.

Test Plan:
- N=1, s0=1, rdy=1, result 3 cycles after accept: command stream ADD0 only. dbl_cnt=0, add_cnt=1, res_inf=0.
- N=1, s0=5: stream ADD0, DBL, DBL, ADD0. dbl_cnt=2, add_cnt=2.
- N=2, s0=3, s1=2: stream ADD0, ADD1, DBL, ADD0 (bit1: j0, j1; bit0: DBL, j0). Counts 1/3.
- N=4, all scalars 0: no o_cmd_val ever. o_done at 1281 cycles after start. res_inf=1, counts 0. N=0: o_done next cycle.
- N=1, s0=5, i_cmd_rdy low for 10 cycles per command: o_cmd_val/op/idx stable throughout. Spurious i_res_val in SCAN is ignored. Start and scalar writes during busy are dropped; s0 is unchanged afterwards.
- Assert i_rst during ADD_WAIT of the s0=5 run: outputs return to reset values immediately. A subsequent s0 write and start run cleanly. Also check i_num=9 with NUM_IN=8 clamps to 8.
